// File: rtl/core_pkg.sv
// ============================================================================
// Module   : core_pkg
// Desc     : Shared LSU types: FSM state encoding, RV32I load/store funct3
//            codes and the access-size byte-mask helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RSP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-lane mask for an access size; funct3[1:0] carries the size code.
  function automatic logic [3:0] size_mask(input logic [1:0] size_code);
    case (size_code)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_if.sv
// ============================================================================
// Module   : lsu_if
// Desc     : Request/response and memory-side bundle of the LSU.
//            master = requester/memory side, slave = the LSU itself.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_load;
  logic             req_store;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_byteen;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_load, req_store, funct3, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );

  modport slave (
    input  req_valid, req_load, req_store, funct3, addr, wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata, mem_byteen
  );
endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ============================================================================
// Module   : lsu_load_align
// Desc     : Picks the addressed bytes out of an 8-byte read window and
//            sign/zero-extends them according to the load funct3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_align
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] window,
  input  logic [1:0]         offset,
  input  logic [2:0]         funct3,
  output logic [WIDTH-1:0]   result
);

  logic [5:0]       w_shift;
  logic [WIDTH-1:0] w_word;

  // The byte at the access offset lands in lane 0 of w_word.
  assign w_shift = {1'b0, offset, 3'b000};
  assign w_word  = window[w_shift +: WIDTH];

  // Extend the selected byte/half/word to full width.
  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{(WIDTH-8){w_word[7]}}, w_word[7:0]};
      F3_LH:   result = {{(WIDTH-16){w_word[15]}}, w_word[15:0]};
      F3_LW:   result = w_word;
      F3_LBU:  result = {{(WIDTH-8){1'b0}}, w_word[7:0]};
      F3_LHU:  result = {{(WIDTH-16){1'b0}}, w_word[15:0]};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// Module   : lsu
// Desc     : RV32I load/store unit. One request at a time; byte/half/word
//            accesses mapped onto a word-wide memory with lane enables.
// Config   : MISALIGNED_SPLIT_EN - when defined, word-boundary-crossing
//            accesses are split into two memory cycles; when undefined,
//            any non-naturally-aligned access returns an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  lsu_if.slave bus
);

  lsu_state_t         r_state;
  lsu_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH-1:0]   r_lo_data;
  logic [2:0]         r_funct3;
  logic               r_load;
  logic               r_store;
  logic               r_err;

  logic               w_type_ok;
  logic               w_f3_ok;
  logic               w_misaligned;
  logic               w_req_err;
  logic               w_accept;
  logic [1:0]         w_off;
  logic [7:0]         w_mask8;
  logic [2*WIDTH-1:0] w_data64;
  logic [2*WIDTH-1:0] w_window;
  logic [WIDTH-1:0]   w_word_addr;
  logic [WIDTH-1:0]   w_load_result;
  logic               w_split;

  logic               w_req_ready;
  logic               w_resp_valid;
  logic               w_resp_err;
  logic [WIDTH-1:0]   w_resp_rdata;
  logic               w_mem_read;
  logic               w_mem_write;
  logic [WIDTH-1:0]   w_mem_addr;
  logic [WIDTH-1:0]   w_mem_wdata;
  logic [3:0]         w_mem_byteen;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // Decide at acceptance whether the request is rejected without a memory access.
  always_comb begin
    w_type_ok    = bus.req_load ^ bus.req_store;
    w_f3_ok      = 1'b0;
    w_misaligned = 1'b0;
    if (bus.req_load) begin
      case (bus.funct3)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_f3_ok = 1'b1;
        default:                            w_f3_ok = 1'b0;
      endcase
    end else begin
      case (bus.funct3)
        F3_SB, F3_SH, F3_SW: w_f3_ok = 1'b1;
        default:             w_f3_ok = 1'b0;
      endcase
    end
`ifndef MISALIGNED_SPLIT_EN
    case (bus.funct3[1:0])
      2'b01:   w_misaligned = bus.addr[0];
      2'b10:   w_misaligned = |bus.addr[1:0];
      default: w_misaligned = 1'b0;
    endcase
`endif
    w_req_err = !w_type_ok || !w_f3_ok || w_misaligned;
  end

  // Lane placement: the upper nibble/word of the 8-lane view spills into the next word.
  assign w_off       = r_addr[1:0];
  assign w_mask8     = {4'b0000, size_mask(r_funct3[1:0])} << w_off;
  assign w_data64    = {{WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};
  assign w_word_addr = {r_addr[WIDTH-1:2], 2'b00};

`ifdef MISALIGNED_SPLIT_EN
  assign w_split = |w_mask8[7:4];
`else
  assign w_split = 1'b0;
`endif

  // In RSP, mem_rdata carries the last word read; a split load pairs it with the first.
  assign w_window = w_split ? {bus.mem_rdata, r_lo_data}
                            : {{WIDTH{1'b0}}, bus.mem_rdata};

  lsu_load_align #(
    .WIDTH (WIDTH)
  ) u_load_align (
    .window (w_window),
    .offset (w_off),
    .funct3 (r_funct3),
    .result (w_load_result)
  );

  // State register plus request latch and first-word capture for split loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lo_data <= '0;
      r_funct3  <= '0;
      r_load    <= 1'b0;
      r_store   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr   <= bus.addr;
        r_wdata  <= bus.wdata;
        r_funct3 <= bus.funct3;
        r_load   <= bus.req_load;
        r_store  <= bus.req_store;
        r_err    <= w_req_err;
      end
      if ((r_state == ACC1) && r_load) begin
        r_lo_data <= bus.mem_rdata;
      end
    end
  end

  // Next-state and output decode; everything idles at zero outside its state.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_byteen = 4'b0000;
    case (r_state)
      IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_nxt = w_req_err ? RSP : ACC0;
        end
      end
      ACC0: begin
        w_mem_read   = r_load;
        w_mem_write  = r_store;
        w_mem_addr   = w_word_addr;
        w_mem_byteen = w_mask8[3:0];
        w_mem_wdata  = r_store ? w_data64[WIDTH-1:0] : '0;
        w_state_nxt  = w_split ? ACC1 : RSP;
      end
      ACC1: begin
        w_mem_read   = r_load;
        w_mem_write  = r_store;
        w_mem_addr   = w_word_addr + WIDTH'(4);
        w_mem_byteen = w_mask8[7:4];
        w_mem_wdata  = r_store ? w_data64[2*WIDTH-1:WIDTH] : '0;
        w_state_nxt  = RSP;
      end
      RSP: begin
        w_resp_valid = 1'b1;
        w_resp_err   = r_err;
        w_resp_rdata = (r_load && !r_err) ? w_load_result : '0;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_err   = w_resp_err;
  assign bus.resp_rdata = w_resp_rdata;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;
  assign bus.mem_byteen = w_mem_byteen;

endmodule

`default_nettype wire
